// File: rtl/sine_ref_gen.sv
// DDS sine reference for the SPWM comparator: one sample per carrier period.
// Define SINE_REF_GEN_AMP_EN to build the amplitude multiplier stage.
module sine_ref_gen #(
    parameter int PWM_TOP = 3906,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               freq_load,
    input  logic [8:0]         amp,
    output logic [11:0]        Sine_out,
    output logic               sample_stb,
    output logic               freq_ack
);

    localparam int MID   = (PWM_TOP + 1) / 2;
    localparam int AMPL  = PWM_TOP - MID;
    localparam int LUT_N = 1 << LUT_AW;
    localparam int CW    = $clog2(PWM_TOP + 1);

    // Fixed-point Taylor series (Q28) so the ROM is built at elaboration.
    function automatic logic [10:0] lut_val(input int i);
        longint x, x2, term, sum;
        x    = (longint'(421657428) * i) / longint'(LUT_N - 1);
        x2   = (x * x) >>> 28;
        term = x;
        sum  = x;
        for (int k = 1; k < 8; k++) begin
            term = (-((term * x2) >>> 28)) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return 11'((longint'(AMPL) * sum + (longint'(1) <<< 27)) >>> 28);
    endfunction

    logic [10:0] rom [LUT_N];

    for (genvar g = 0; g < LUT_N; g++) begin : g_rom
        localparam logic [10:0] V = lut_val(g);
        assign rom[g] = V;
    end

    logic [CW-1:0]      cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] pending;
    logic               pend_flag;
    logic               v1, v2, v3;
    logic [10:0]        s1_lut;
    logic [1:0]         s1_q;
    logic [10:0]        s2_s;
    logic [1:0]         s2_q;

    logic               adv;
    logic               wrap;
    logic [PHASE_W-1:0] inc_nxt;
    logic [1:0]         q;
    logic [LUT_AW-1:0]  a;
    logic [LUT_AW-1:0]  addr;
    logic [10:0]        s2_nxt;
    logic [11:0]        mid12;
    logic [11:0]        s_ext;

    assign adv     = (cnt == CW'(PWM_TOP - 3));
    assign wrap    = (cnt == CW'(PWM_TOP));
    assign inc_nxt = freq_load ? freq_word : pending;
    assign q       = phase[PHASE_W-1 -: 2];
    assign a       = phase[PHASE_W-3 -: LUT_AW];
    assign addr    = q[0] ? ~a : a;
    assign mid12   = 12'(MID);
    assign s_ext   = {1'b0, s2_s};

`ifdef SINE_REF_GEN_AMP_EN
    logic [8:0]  amp_reg;
    logic [8:0]  amp_sat;
    logic [19:0] prod;

    assign amp_sat = (amp > 9'd256) ? 9'd256 : amp;
    assign prod    = {9'b0, s1_lut} * {11'b0, amp_reg};
    assign s2_nxt  = 11'(prod >> 8);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            amp_reg <= '0;
        end else if (adv) begin
            amp_reg <= amp_sat;
        end
    end
`else
    logic unused_amp;

    assign unused_amp = ^amp;
    assign s2_nxt     = s1_lut;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            phase      <= '0;
            inc        <= '0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            s1_lut     <= '0;
            s1_q       <= '0;
            s2_s       <= '0;
            s2_q       <= '0;
            Sine_out   <= mid12;
            sample_stb <= 1'b0;
            freq_ack   <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;

            if (freq_load) begin
                pending <= freq_word;
            end
            // A load on the advance edge goes straight to the active increment.
            if (adv) begin
                inc       <= inc_nxt;
                phase     <= phase + inc_nxt;
                pend_flag <= 1'b0;
            end else if (freq_load) begin
                pend_flag <= 1'b1;
            end
            freq_ack <= adv & (freq_load | pend_flag);

            v1 <= adv;
            v2 <= v1;
            v3 <= v2;

            if (v1) begin
                s1_lut <= rom[addr];
                s1_q   <= q;
            end
            if (v2) begin
                s2_s <= s2_nxt;
                s2_q <= s1_q;
            end
            if (v3) begin
                Sine_out <= s2_q[1] ? (mid12 - s_ext) : (mid12 + s_ext);
            end
            sample_stb <= v3;
        end
    end

endmodule

// File: tb/tb_sine_ref_gen.sv
// Directed bench for sine_ref_gen: reset, quadrants, amplitude, handshake, wrap.
// Amplitude expectations follow SINE_REF_GEN_AMP_EN.
module tb_sine_ref_gen;

    localparam int          P  = 3907;
    localparam logic [23:0] QW = 24'h400000;

`ifdef SINE_REF_GEN_AMP_EN
    localparam logic [8:0] AMP_T = 9'd128;
    localparam int         E_Q1  = 2929;
    localparam int         E_Q3  = 977;
`else
    localparam logic [8:0] AMP_T = 9'd0;
    localparam int         E_Q1  = 3906;
    localparam int         E_Q3  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] freq_word = '0;
    logic        freq_load = 1'b0;
    logic [8:0]  amp = 9'd256;
    logic [11:0] Sine_out;
    logic        sample_stb;
    logic        freq_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sine_ref_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freq_word  (freq_word),
        .freq_load  (freq_load),
        .amp        (amp),
        .Sine_out   (Sine_out),
        .sample_stb (sample_stb),
        .freq_ack   (freq_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_stb(output int clks, output int ack_at,
                            output int acks);
        clks   = 0;
        ack_at = -1;
        acks   = 0;
        while (clks < 2 * P) begin
            @(negedge clk);
            freq_load = 1'b0;
            clks++;
            if (freq_ack) begin
                acks++;
                ack_at = clks;
            end
            if (sample_stb) break;
        end
        chk("stb_seen", sample_stb, 1);
    endtask

    task automatic next_sample(input string tag, input int exp_v,
                               input int exp_clks, output int ack_at,
                               output int acks);
        int clks;
        wait_stb(clks, ack_at, acks);
        chk({tag, "_period"}, clks, exp_clks);
        chk({tag, "_val"}, Sine_out, exp_v);
        chk({tag, "_range"}, 32'(Sine_out <= 12'd3906), 1);
    endtask

    initial begin
        int ack_at, acks;
        int quad_exp [4];
        int wrap_exp [3];
        quad_exp = '{3906, 1953, 0, 1953};
        wrap_exp = '{3906, 1953, 0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out", Sine_out, 1953);
        chk("rst_stb", sample_stb, 0);
        chk("rst_ack", freq_ack, 0);

        // Reset again with a sample in flight in the pipeline.
        repeat (3905) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out", Sine_out, 1953);
        chk("mid_rst_stb", sample_stb, 0);
        rst_n = 1'b1;
        next_sample("first", 1953, P, ack_at, acks);
        chk("first_acks", acks, 0);

        amp       = 9'd256;
        freq_word = QW;
        freq_load = 1'b1;
        next_sample("quad0", quad_exp[0], P, ack_at, acks);
        chk("quad_acks", acks, 1);
        chk("quad_ack_at", ack_at, P - 3);
        for (int i = 1; i < 4; i++) begin
            next_sample("quad", quad_exp[i], P, ack_at, acks);
            chk("quad_noack", acks, 0);
        end

        amp = AMP_T;
        next_sample("amp_q1", E_Q1, P, ack_at, acks);
        next_sample("amp_q2", 1953, P, ack_at, acks);
        next_sample("amp_q3", E_Q3, P, ack_at, acks);
        amp = 9'd400;

        // Two loads in one period: only the second word takes effect.
        freq_word = QW;
        freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        repeat (9) @(negedge clk);
        freq_word = 24'h800000;
        freq_load = 1'b1;
        next_sample("hs", 3906, P - 10, ack_at, acks);
        chk("hs_acks", acks, 1);
        chk("hs_ack_at", ack_at, P - 13);

        repeat (3903) @(negedge clk);
        freq_word = QW;
        freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        chk("adv_ack", freq_ack, 1);
        next_sample("adv", 1953, 3, ack_at, acks);
        chk("adv_acks", acks, 0);

        freq_word = 24'hC00000;
        freq_load = 1'b1;
        next_sample("wrap0", wrap_exp[0], P, ack_at, acks);
        chk("wrap_acks", acks, 1);
        for (int i = 1; i < 3; i++) begin
            next_sample("wrap", wrap_exp[i], P, ack_at, acks);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
